// File: rtl/ad_pkg.sv
// Shared types and constants for the capped movie-ad selector.
// Holds the ad index enum, the default genre masks and the helper that
// finds the next eligible ad above a blocked one.
package ad_pkg;

    typedef enum logic [1:0] {
        AD_DIEHARD   = 2'd0,
        AD_SAFEHAVEN = 2'd1,
        AD_ESCAPE    = 2'd2,
        AD_LINCOLN   = 2'd3
    } ad_t;

    // Genre bits: 0 action, 1 romance, 2 comedy, 3 thriller.
    localparam logic [3:0] HERO_MASK_DEF    = 4'b1001;
    localparam logic [3:0] ROMANCE_MASK_DEF = 4'b0010;
    localparam logic [3:0] FEXEMPT_MASK_DEF = 4'b0100;
    localparam logic [3:0] FAMILY_MASK_DEF  = 4'b0101;

    // Lowest eligible ad strictly above raw. Ad 3 is always eligible, so it
    // is the natural fallback when nothing else qualifies.
    function automatic ad_t next_eligible(input ad_t raw, input logic [3:0] e);
        ad_t r;
        r = AD_LINCOLN;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(raw) && e[i]) r = ad_t'(2'(i));
        end
        return r;
    endfunction

endpackage

// File: rtl/ad_classify.sv
// Combinational genre classifier: per-ad eligibility and the priority pick.
// The mask parameters program which genres feed each ad rule.
module ad_classify
    import ad_pkg::*;
#(
    parameter int                TW           = 2,
    parameter logic [2**TW-1:0]  HERO_MASK    = HERO_MASK_DEF,
    parameter logic [2**TW-1:0]  ROMANCE_MASK = ROMANCE_MASK_DEF,
    parameter logic [2**TW-1:0]  FEXEMPT_MASK = FEXEMPT_MASK_DEF,
    parameter logic [2**TW-1:0]  FAMILY_MASK  = FAMILY_MASK_DEF
) (
    input  logic          a,
    input  logic          f,
    input  logic [TW-1:0] t,
    output logic [3:0]    e,
    output ad_t           raw
);

    // Eligibility per ad, then lowest eligible index wins.
    always_comb begin
        e[0] = HERO_MASK[t] & ~a & ~f;
        e[1] = ROMANCE_MASK[t] | (f & ~FEXEMPT_MASK[t]);
        e[2] = a | FAMILY_MASK[t];
        e[3] = 1'b1;
        if (e[0])      raw = AD_DIEHARD;
        else if (e[1]) raw = AD_SAFEHAVEN;
        else if (e[2]) raw = AD_ESCAPE;
        else           raw = AD_LINCOLN;
    end

endmodule

// File: rtl/ad_selector_capped.sv
// Capped movie-ad selector: classifies one record per handshake, demotes an
// ad that has already been served CAP times in a row, and presents the
// result through a one-entry output register.
// Optional build macro AD_STATS_EN adds saturating per-ad serve counters on
// the stats_count port.
module ad_selector_capped
    import ad_pkg::*;
#(
    parameter int                TW           = 2,
    parameter logic [2**TW-1:0]  HERO_MASK    = HERO_MASK_DEF,
    parameter logic [2**TW-1:0]  ROMANCE_MASK = ROMANCE_MASK_DEF,
    parameter logic [2**TW-1:0]  FEXEMPT_MASK = FEXEMPT_MASK_DEF,
    parameter logic [2**TW-1:0]  FAMILY_MASK  = FAMILY_MASK_DEF,
    parameter int                CAP          = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_a,
    input  logic          in_f,
    input  logic [TW-1:0] in_t,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_m,
    output logic          out_capped
`ifdef AD_STATS_EN
    ,
    output logic [63:0]   stats_count
`endif
);

    localparam int RW = (CAP < 1) ? 1 : $clog2(CAP + 1);
    localparam logic [RW-1:0] CAP_R = RW'(CAP);

    logic [3:0]    e;
    ad_t           raw;
    ad_t           chosen;
    ad_t           last_m;
    logic [RW-1:0] run;
    logic          blocked;
    logic          accept;

    ad_classify #(
        .TW           (TW),
        .HERO_MASK    (HERO_MASK),
        .ROMANCE_MASK (ROMANCE_MASK),
        .FEXEMPT_MASK (FEXEMPT_MASK),
        .FAMILY_MASK  (FAMILY_MASK)
    ) u_classify (
        .a   (in_a),
        .f   (in_f),
        .t   (in_t),
        .e   (e),
        .raw (raw)
    );

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Cap check: the fallback ad is never blocked.
    always_comb begin
        blocked = (CAP != 0) && (raw != AD_LINCOLN) && (raw == last_m) && (run == CAP_R);
        chosen  = blocked ? next_eligible(raw, e) : raw;
    end

    // Output register and run tracking; idle cycles leave the run intact.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_m      <= 2'd0;
            out_capped <= 1'b0;
            last_m     <= AD_DIEHARD;
            run        <= '0;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_m      <= chosen;
                out_capped <= blocked;
                last_m     <= chosen;
                if (chosen == last_m && run != '0)
                    run <= (run >= CAP_R) ? CAP_R : run + 1'b1;
                else
                    run <= RW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef AD_STATS_EN
    logic [15:0] cnt [4];

    // Saturating serve counters, one per ad.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) cnt[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < 4; k++) begin
                if (chosen == ad_t'(2'(k)) && cnt[k] != 16'hFFFF)
                    cnt[k] <= cnt[k] + 16'd1;
            end
        end
    end

    assign stats_count = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_ad_selector_capped.sv
// Bench for ad_selector_capped: three instances sharing one stimulus stream
// (uncapped legacy, CAP=3 defaults, CAP=3 with no romance genre so that the
// fallback ad is reachable). Expected values are hand-derived.
module tb_ad_selector_capped;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_a, in_f;
    logic [1:0] in_t;
    logic       out_ready;

    logic       rdy0, rdy1, rdy2;
    logic       ov0, ov1, ov2;
    logic [1:0] m0, m1, m2;
    logic       c0, c1, c2;
`ifdef AD_STATS_EN
    logic [63:0] st0, st1, st2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    ad_selector_capped #(.CAP(0)) dut_legacy (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_f(in_f), .in_t(in_t), .out_valid(ov0),
        .out_ready(out_ready), .out_m(m0), .out_capped(c0)
`ifdef AD_STATS_EN
        , .stats_count(st0)
`endif
    );

    ad_selector_capped #(.CAP(3)) dut_cap (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a), .in_f(in_f), .in_t(in_t), .out_valid(ov1),
        .out_ready(out_ready), .out_m(m1), .out_capped(c1)
`ifdef AD_STATS_EN
        , .stats_count(st1)
`endif
    );

    ad_selector_capped #(.CAP(3), .ROMANCE_MASK(4'b0000)) dut_exempt (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
        .in_a(in_a), .in_f(in_f), .in_t(in_t), .out_valid(ov2),
        .out_ready(out_ready), .out_m(m2), .out_capped(c2)
`ifdef AD_STATS_EN
        , .stats_count(st2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Legacy selector written in genre terms (0 action, 1 romance, 2 comedy, 3 thriller).
    function automatic logic [1:0] legacy(input logic a, input logic f, input logic [1:0] t);
        if (!a && !f && (t == 2'd0 || t == 2'd3)) return 2'd0;
        if (t == 2'd1 || (f && t != 2'd2))        return 2'd1;
        if (a || t == 2'd0 || t == 2'd2)          return 2'd2;
        return 2'd3;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic a, input logic f, input logic [1:0] t);
        in_a = a; in_f = f; in_t = t; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [1:0] exp_m [5];
    logic       exp_c [5];

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_a = 1'b0; in_f = 1'b0; in_t = 2'd0;
        out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", 64'(ov0), 64'd0);
        check("rst_m", 64'(m0), 64'd0);
        check("rst_capped", 64'(c0), 64'd0);
        check("rst_ready", 64'(rdy0), 64'd1);

        // Legacy sweep on the uncapped instance, one-cycle latency
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            send(v[3], v[2], v[1:0]);
            check($sformatf("legacy_valid_%0d", i), 64'(ov0), 64'd1);
            check($sformatf("legacy_m_%0d", i), 64'(m0), 64'(legacy(v[3], v[2], v[1:0])));
            check($sformatf("legacy_cap_%0d", i), 64'(c0), 64'd0);
        end
        tick();
        check("drain_valid", 64'(ov0), 64'd0);

        // Cap of ad 0 demotes to ad 2 via the action family bit
        do_reset();
        exp_m = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
        exp_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 1'b0, 2'd0);
            check($sformatf("cap0_m_%0d", i), 64'(m1), 64'(exp_m[i]));
            check($sformatf("cap0_c_%0d", i), 64'(c1), 64'(exp_c[i]));
        end

        // Animated thriller: ad 2 three times, then demoted to the fallback
        do_reset();
        exp_m = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
        exp_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b0, 2'd3);
            check($sformatf("cap2_m_%0d", i), 64'(m1), 64'(exp_m[i]));
            check($sformatf("cap2_c_%0d", i), 64'(c1), 64'(exp_c[i]));
        end

        // Fallback ad is never capped (romance-less instance picks ad 3)
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 1'b0, 2'd1);
            check($sformatf("exempt_m_%0d", i), 64'(m2), 64'd3);
            check($sformatf("exempt_c_%0d", i), 64'(c2), 64'd0);
        end

        // Idle cycles do not break the run
        do_reset();
        send(1'b0, 1'b0, 2'd0);
        send(1'b0, 1'b0, 2'd0);
        tick(); tick();
        send(1'b0, 1'b0, 2'd0);
        check("idle_third_m", 64'(m1), 64'd0);
        send(1'b0, 1'b0, 2'd0);
        check("idle_fourth_m", 64'(m1), 64'd2);
        check("idle_fourth_c", 64'(c1), 64'd1);

        // Backpressure: one accept, then stall with stable output
        do_reset();
        out_ready = 1'b0;
        in_a = 1'b0; in_f = 1'b0; in_t = 2'd2; in_valid = 1'b1;
        tick();
        in_f = 1'b1; in_t = 2'd3;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_ready_%0d", i), 64'(rdy0), 64'd0);
            check($sformatf("bp_m_%0d", i), 64'(m0), 64'd2);
            check($sformatf("bp_valid_%0d", i), 64'(ov0), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("handover_ready", 64'(rdy0), 64'd1);
        tick();
        in_valid = 1'b0;
        check("handover_valid", 64'(ov0), 64'd1);
        check("handover_m", 64'(m0), 64'd1);
        tick();
        check("handover_drain", 64'(ov0), 64'd0);

        // Reset mid-stream with a pending output and run of 2
        do_reset();
        send(1'b0, 1'b0, 2'd0);
        send(1'b0, 1'b0, 2'd0);
        out_ready = 1'b0;
        check("pre_rst_valid", 64'(ov1), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_valid", 64'(ov1), 64'd0);
        check("mid_rst_m", 64'(m1), 64'd0);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0, 2'd0);
            check($sformatf("post_rst_m_%0d", i), 64'(m1), 64'd0);
            check($sformatf("post_rst_c_%0d", i), 64'(c1), 64'd0);
        end

`ifdef AD_STATS_EN
        // Saturation of the ad 1 counter on the uncapped instance
        do_reset();
        check("stats_clear", st0, 64'd0);
        in_a = 1'b0; in_f = 1'b0; in_t = 2'd1; in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("stats_ad1_sat", 64'(st0[31:16]), 64'hFFFF);
        check("stats_ad0", 64'(st0[15:0]), 64'd0);
        check("stats_ad2", 64'(st0[47:32]), 64'd0);
        check("stats_ad3", 64'(st0[63:48]), 64'd0);
        do_reset();
        check("stats_reset", st0, 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
